// File: rtl/floating_point_accumulator.sv
// Streaming IEEE-754 accumulator around one round-to-nearest-even adder (subnormals flush to zero).
// Define FLOATING_POINT_ACCUMULATOR_COUNT_EN to add the out_count beat-count port.

module floating_point_adder #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
    input  logic                                   subtract,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result,
    output logic                                   underflow_flag,
    output logic                                   overflow_flag,
    output logic                                   invalid_operation_flag
);
    localparam int E  = EXPONENT_WIDTH;
    localparam int M  = MANTISSA_WIDTH;
    localparam int FW = E + M + 1;
    localparam int W  = M + 4;  // hidden bit, fraction, guard, round, sticky
    localparam logic [E-1:0] EXP_MAX   = '1;
    localparam logic [M-1:0] QNAN_FRAC = {1'b1, {(M-1){1'b0}}};

    logic                sa, sb, sl, ss;
    logic [E-1:0]        ea, eb, el, es, shift;
    logic [M-1:0]        fa, fb, frac;
    logic [W-1:0]        ml, ms, ms_sh, lost_mask, norm;
    logic [W:0]          sum;
    logic signed [E+1:0] exp_n;
    logic [M+1:0]        mant_r;
    logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sticky, round_up;
    int                  lz;

    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        sa = a[FW-1];
        ea = a[FW-2:M];
        fa = a[M-1:0];
        sb = b[FW-1] ^ subtract;
        eb = b[FW-2:M];
        fb = b[M-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EXP_MAX) && (fa == '0);
        b_inf  = (eb == EXP_MAX) && (fb == '0);
        a_nan  = (ea == EXP_MAX) && (fa != '0);
        b_nan  = (eb == EXP_MAX) && (fb != '0);

        // Larger magnitude first so the mantissa difference is never negative.
        if ({ea, fa} >= {eb, fb}) begin
            sl = sa; el = ea; ml = {1'b1, fa, 3'b000};
            ss = sb; es = eb; ms = {1'b1, fb, 3'b000};
        end else begin
            sl = sb; el = eb; ml = {1'b1, fb, 3'b000};
            ss = sa; es = ea; ms = {1'b1, fa, 3'b000};
        end
        shift     = el - es;
        ms_sh     = ms >> shift;
        lost_mask = ~({W{1'b1}} << shift);
        sticky    = |(ms & lost_mask);
        if (sl == ss) sum = {1'b0, ml} + {1'b0, ms_sh | W'(sticky)};
        else          sum = {1'b0, ml} - {1'b0, ms_sh | W'(sticky)};

        lz = W;
        for (int i = 0; i < W; i++) begin
            if (sum[i]) lz = W - 1 - i;
        end
        if (sum[W]) begin
            norm  = sum[W:1] | W'(sum[0]);
            exp_n = $signed({2'b00, el}) + (E+2)'(1);
        end else begin
            norm  = sum[W-1:0] << lz;
            exp_n = $signed({2'b00, el}) - (E+2)'(lz);
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[W-1:3]} + (M+2)'(round_up);
        if (mant_r[M+1]) begin
            exp_n = exp_n + (E+2)'(1);
            frac  = mant_r[M:1];
        end else begin
            frac  = mant_r[M-1:0];
        end

        result                 = {sl, exp_n[E-1:0], frac};
        underflow_flag         = 1'b0;
        overflow_flag          = 1'b0;
        invalid_operation_flag = 1'b0;
        if (exp_n >= $signed({2'b00, EXP_MAX})) begin
            result        = {sl, EXP_MAX, {M{1'b0}}};
            overflow_flag = 1'b1;
        end else if (exp_n[E+1] || (exp_n == '0)) begin
            result         = {sl, {(FW-1){1'b0}}};
            underflow_flag = 1'b1;
        end
        if (sum == '0) result = '0;

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            result                 = {1'b1, EXP_MAX, QNAN_FRAC};
            overflow_flag          = 1'b0;
            underflow_flag         = 1'b0;
            invalid_operation_flag = 1'b1;
        end else if (a_inf || b_inf) begin
            result         = {(a_inf ? sa : sb), EXP_MAX, {M{1'b0}}};
            overflow_flag  = 1'b1;
            underflow_flag = 1'b0;
        end else if (a_zero || b_zero) begin
            overflow_flag  = 1'b0;
            underflow_flag = 1'b0;
            if (a_zero && b_zero) result = {sa & sb, {(FW-1){1'b0}}};
            else if (a_zero)      result = {sb, eb, fb};
            else                  result = {sa, ea, fa};
        end
    end
endmodule

module floating_point_accumulator #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int COUNT_WIDTH    = 16,
    localparam int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FLOAT_BIT_WIDTH-1:0] in_data,
    input  logic                       in_subtract,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FLOAT_BIT_WIDTH-1:0] out_data,
    output logic                       out_underflow_flag,
    output logic                       out_overflow_flag,
`ifdef FLOATING_POINT_ACCUMULATOR_COUNT_EN
    output logic [COUNT_WIDTH-1:0]     out_count,
`endif
    output logic                       out_invalid_operation_flag
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

    state_e                     state_q, state_d;
    logic [FLOAT_BIT_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d, add_result;
    logic [2:0]                 sticky_q, sticky_d, out_flags_q, out_flags_d, add_flags;
    logic                       accept;

    if (COUNT_WIDTH < 1 || EXPONENT_WIDTH < 2 || MANTISSA_WIDTH < 2) begin : g_param_check
        $error("floating_point_accumulator: field and counter widths too small");
    end

    floating_point_adder #(
        .EXPONENT_WIDTH(EXPONENT_WIDTH),
        .MANTISSA_WIDTH(MANTISSA_WIDTH)
    ) u_adder (
        .a                     (acc_q),
        .b                     (in_data),
        .subtract              (in_subtract),
        .result                (add_result),
        .underflow_flag        (add_flags[2]),
        .overflow_flag         (add_flags[1]),
        .invalid_operation_flag(add_flags[0])
    );

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign out_data  = out_data_q;
    assign {out_underflow_flag, out_overflow_flag, out_invalid_operation_flag} = out_flags_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        if (state_q == HOLD) begin
            if (out_ready) begin
                state_d  = IDLE;
                acc_d    = '0;
                sticky_d = '0;
            end
        end else if (accept) begin
            acc_d    = add_result;
            sticky_d = sticky_q | add_flags;
            state_d  = in_last ? HOLD : ACCUM;
            if (in_last) begin
                out_data_d  = add_result;
                out_flags_d = sticky_q | add_flags;
            end
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sticky_q    <= '0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

`ifdef FLOATING_POINT_ACCUMULATOR_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q, count_d, out_count_q, out_count_d;

    always_comb begin
        count_d     = count_q;
        out_count_d = out_count_q;
        if (state_q == HOLD) begin
            if (out_ready) count_d = '0;
        end else if (accept) begin
            count_d = count_q + 1'b1;
            if (in_last) out_count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            out_count_q <= '0;
        end else begin
            count_q     <= count_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_count = out_count_q;
`endif
endmodule

// File: tb/tb_floating_point_accumulator.sv
// Directed and randomized checks of floating_point_accumulator against a double-precision model.
// Honors FLOATING_POINT_ACCUMULATOR_COUNT_EN to also check out_count.

module tb_floating_point_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_subtract = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_underflow_flag, out_overflow_flag, out_invalid_operation_flag;
`ifdef FLOATING_POINT_ACCUMULATOR_COUNT_EN
    logic [15:0] out_count;
`endif
    int errors = 0;
    int checks = 0;

    floating_point_accumulator dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .in_data                   (in_data),
        .in_subtract               (in_subtract),
        .in_last                   (in_last),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_data                  (out_data),
        .out_underflow_flag        (out_underflow_flag),
        .out_overflow_flag         (out_overflow_flag),
`ifdef FLOATING_POINT_ACCUMULATOR_COUNT_EN
        .out_count                 (out_count),
`endif
        .out_invalid_operation_flag(out_invalid_operation_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact single-to-double widening of a normal (or zero) single.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    // Round a double to single precision, nearest-even (normal range only).
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [23:0] m;
        logic [28:0] rem;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'b0};
        e   = int'(d[62:52]) - 1023 + 127;
        m   = {1'b0, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 24'd1;
        if (m[23]) begin
            e++;
            m = '0;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    task automatic send(input logic [31:0] d, input logic sub, input logic last);
        check("in_ready_before_beat", in_ready, 1);
        in_valid    = 1'b1;
        in_data     = d;
        in_subtract = sub;
        in_last     = last;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_data     = $urandom;
        in_subtract = 1'($urandom);
        in_last     = 1'($urandom);
        if (!last) check("out_valid_mid_sum", out_valid, 0);
    endtask

    task automatic expect_sum(input string tag, input logic [31:0] data, input logic [2:0] flags,
                              input int beats);
        check({tag, " valid"}, out_valid, 1);
        check({tag, " data"}, out_data, data);
        check({tag, " flags"}, {out_underflow_flag, out_overflow_flag, out_invalid_operation_flag}, flags);
`ifdef FLOATING_POINT_ACCUMULATOR_COUNT_EN
        check({tag, " count"}, out_count, 64'(16'(beats)));
`endif
    endtask

    task automatic release_result(input logic [31:0] held);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_accept", out_valid, 0);
        check("out_data_kept_in_idle", out_data, held);
        check("in_ready_in_idle", in_ready, 1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset flags", {out_underflow_flag, out_overflow_flag, out_invalid_operation_flag}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset in_ready", in_ready, 1);

        send(32'h4040_0000, 1'b0, 1'b0);
        send(32'h4080_0000, 1'b0, 1'b1);
        expect_sum("sum_3_4", 32'h40E0_0000, 3'b000, 2);
        release_result(32'h40E0_0000);

        send(32'h410B_3333, 1'b0, 1'b0);
        send(32'h3E99_999A, 1'b0, 1'b1);
        expect_sum("sum_8p7_0p3", 32'h4110_0000, 3'b000, 2);
        release_result(32'h4110_0000);
        send(32'h4040_0000, 1'b1, 1'b1);
        expect_sum("single_sub_3", 32'hC040_0000, 3'b000, 1);
        release_result(32'hC040_0000);

        send(32'h7F80_0000, 1'b0, 1'b0);
        send(32'h7F80_0000, 1'b1, 1'b1);
        expect_sum("inf_minus_inf", 32'hFFC0_0000, 3'b011, 2);
        release_result(32'hFFC0_0000);

        send(32'h7F7F_FFFF, 1'b0, 1'b0);
        send(32'h7F7F_FFFF, 1'b0, 1'b1);
        expect_sum("max_plus_max", 32'h7F80_0000, 3'b010, 2);
        release_result(32'h7F80_0000);

        send(32'h4040_0000, 1'b0, 1'b0);
        send(32'h4080_0000, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h3F80_0000;
            in_last  = 1'b1;
            @(posedge clk); #1;
            check("hold out_data", out_data, 32'h40E0_0000);
            check("hold in_ready", in_ready, 0);
            check("hold out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        expect_sum("after_hold", 32'h40E0_0000, 3'b000, 2);
        release_result(32'h40E0_0000);
        send(32'h3F80_0000, 1'b0, 1'b1);
        expect_sum("fresh_after_hold", 32'h3F80_0000, 3'b000, 1);
        release_result(32'h3F80_0000);

        send(32'h4040_0000, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midsum_reset out_valid", out_valid, 0);
        check("midsum_reset out_data", out_data, 0);
        check("midsum_reset flags", {out_underflow_flag, out_overflow_flag, out_invalid_operation_flag}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h4080_0000, 1'b0, 1'b1);
        expect_sum("after_reset", 32'h4080_0000, 3'b000, 1);
        release_result(32'h4080_0000);

        for (int s = 0; s < 25; s++) begin
            int          n;
            logic [31:0] model;
            logic [31:0] x;
            logic        sub;
            real         r;
            n     = $urandom_range(1, 6);
            model = '0;
            for (int k = 0; k < n; k++) begin
                x     = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
                sub   = 1'($urandom);
                r     = sub ? f2r(model) - f2r(x) : f2r(model) + f2r(x);
                model = r2f(r);
                send(x, sub, k == n - 1);
                if (k < n - 1) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
            expect_sum("random", model, 3'b000, n);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check("random held", out_data, model);
            release_result(model);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
